// File: rtl/matrix_mult_seq.sv
// Sequential NxN matrix multiplier, C = A x B, one multiply-accumulate per clock.
// Operands are captured on start; c_flat updates atomically with the done pulse.
module matrix_mult_seq #(
    parameter int unsigned N      = 2,
    parameter int unsigned DW     = 32,
    parameter int unsigned SIGNED = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [N*N*DW-1:0]                  a_flat,
    input  logic [N*N*DW-1:0]                  b_flat,
    output logic                               busy,
    output logic                               done,
    output logic [N*N*(2*DW+$clog2(N))-1:0]    c_flat
);

    localparam int unsigned ACC_W = 2*DW + $clog2(N);
    localparam int unsigned IW    = $clog2(N);
    localparam int unsigned PW    = 2*DW + 2;
    localparam int unsigned CW    = N*N*ACC_W;
    localparam logic [IW-1:0] LAST = IW'(N-1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_n;
    logic [DW-1:0]     a_q [N][N];
    logic [DW-1:0]     a_n [N][N];
    logic [DW-1:0]     b_q [N][N];
    logic [DW-1:0]     b_n [N][N];
    logic [ACC_W-1:0]  sh_q [N][N];
    logic [ACC_W-1:0]  sh_n [N][N];
    logic [ACC_W-1:0]  acc_q, acc_n;
    logic [IW-1:0]     i_q, i_n, j_q, j_n, k_q, k_n;
    logic              busy_q, busy_n, done_q, done_n;
    logic [CW-1:0]     c_q, c_n;

    // MAC datapath: extend by one bit so a single signed multiply serves both modes
    logic [DW-1:0]        a_el, b_el;
    logic signed [DW:0]   a_ext, b_ext;
    logic signed [PW-1:0] prod;
    logic [ACC_W-1:0]     acc_sum;

    assign a_el    = a_q[i_q][k_q];
    assign b_el    = b_q[k_q][j_q];
    assign a_ext   = {(SIGNED != 0) & a_el[DW-1], a_el};
    assign b_ext   = {(SIGNED != 0) & b_el[DW-1], b_el};
    assign prod    = a_ext * b_ext;
    assign acc_sum = acc_q + ACC_W'(prod);

    // Next-state and datapath control
    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        b_n     = b_q;
        sh_n    = sh_q;
        acc_n   = acc_q;
        i_n     = i_q;
        j_n     = j_q;
        k_n     = k_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        c_n     = c_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    for (int r = 0; r < int'(N); r++) begin
                        for (int s = 0; s < int'(N); s++) begin
                            a_n[r][s] = a_flat[(r*N+s)*DW +: DW];
                            b_n[r][s] = b_flat[(r*N+s)*DW +: DW];
                        end
                    end
                    i_n     = '0;
                    j_n     = '0;
                    k_n     = '0;
                    acc_n   = '0;
                    busy_n  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (k_q != LAST) begin
                    acc_n = acc_sum;
                    k_n   = k_q + 1'b1;
                end else begin
                    sh_n[i_q][j_q] = acc_sum;
                    acc_n = '0;
                    k_n   = '0;
                    if (j_q != LAST) begin
                        j_n = j_q + 1'b1;
                    end else begin
                        j_n = '0;
                        i_n = i_q + 1'b1;
                    end
                    // Final element: publish the whole shadow matrix in one edge
                    if (i_q == LAST && j_q == LAST) begin
                        i_n = '0;
                        for (int r = 0; r < int'(N); r++) begin
                            for (int s = 0; s < int'(N); s++) begin
                                c_n[(r*N+s)*ACC_W +: ACC_W] = sh_n[r][s];
                            end
                        end
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = DONE;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int r = 0; r < int'(N); r++) begin
                for (int s = 0; s < int'(N); s++) begin
                    a_q[r][s]  <= '0;
                    b_q[r][s]  <= '0;
                    sh_q[r][s] <= '0;
                end
            end
            acc_q  <= '0;
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            c_q    <= '0;
        end else begin
            state_q <= state_n;
            a_q     <= a_n;
            b_q     <= b_n;
            sh_q    <= sh_n;
            acc_q   <= acc_n;
            i_q     <= i_n;
            j_q     <= j_n;
            k_q     <= k_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            c_q     <= c_n;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign c_flat = c_q;

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Scoreboard bench for matrix_mult_seq: unsigned/signed N=2 DW=32 and N=3 DW=8 instances.
module tb_matrix_mult_seq;

    localparam int unsigned CW = 260;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] a0, b0, a1, b1;
    logic [71:0]  a2, b2;
    logic         st0, st1, st2;
    logic         bz0, bz1, bz2, dn0, dn1, dn2;
    logic [259:0] c0, c1;
    logic [161:0] c2;

    matrix_mult_seq #(.N(2), .DW(32), .SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(st0), .a_flat(a0), .b_flat(b0),
        .busy(bz0), .done(dn0), .c_flat(c0));
    matrix_mult_seq #(.N(2), .DW(32), .SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .start(st1), .a_flat(a1), .b_flat(b1),
        .busy(bz1), .done(dn1), .c_flat(c1));
    matrix_mult_seq #(.N(3), .DW(8), .SIGNED(0)) u_n3 (
        .clk(clk), .rst_n(rst_n), .start(st2), .a_flat(a2), .b_flat(b2),
        .busy(bz2), .done(dn2), .c_flat(c2));

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CW-1:0] c;
        int unsigned   at;
    } exp_t;

    exp_t          sb [3][$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] c_v    [3];
    logic          done_v [3];
    logic          busy_v [3];

    assign c_v[0] = c0;
    assign c_v[1] = c1;
    assign c_v[2] = CW'(c2);
    assign done_v[0] = dn0;
    assign done_v[1] = dn1;
    assign done_v[2] = dn2;
    assign busy_v[0] = bz0;
    assign busy_v[1] = bz1;
    assign busy_v[2] = bz2;

    task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor: every done pops one expectation; c_flat must not move otherwise
    initial begin : monitor
        logic [CW-1:0] prev_c [3];
        logic          prev_rst;
        exp_t          e;
        prev_rst = 1'b0;
        for (int u = 0; u < 3; u++) prev_c[u] = '0;
        forever begin
            @(negedge clk);
            for (int u = 0; u < 3; u++) begin
                if (done_v[u] === 1'b1) begin
                    if (sb[u].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done unit=%0d cycle=%0d", u, cyc);
                    end else begin
                        e = sb[u].pop_front();
                        check($sformatf("c_flat_u%0d", u), c_v[u], e.c);
                        check($sformatf("done_cycle_u%0d", u), CW'(cyc), CW'(e.at));
                    end
                end else if (rst_n && prev_rst && c_v[u] !== prev_c[u]) begin
                    checks++;
                    errors++;
                    $display("FAIL c_flat_moved unit=%0d got=%0h was=%0h", u, c_v[u], prev_c[u]);
                end
                prev_c[u] = c_v[u];
            end
            prev_rst = rst_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_start(input int u, input logic v);
        case (u)
            0:       st0 = v;
            1:       st1 = v;
            default: st2 = v;
        endcase
    endtask

    task automatic expect_job(input int u, input logic [CW-1:0] c, input int unsigned at);
        exp_t e;
        e.c  = c;
        e.at = at;
        sb[u].push_back(e);
    endtask

    task automatic wait_done(input int u, input int unsigned budget, output int unsigned nbusy);
        bit seen;
        nbusy = 0;
        seen  = 1'b0;
        for (int unsigned n = 0; n < budget; n++) begin
            if (done_v[u] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy_v[u] === 1'b1) nbusy++;
            tick();
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout unit=%0d got=none want=done within %0d", u, budget);
        end
    endtask

    // One-cycle start pulse, then wait for done and count busy cycles
    task automatic do_job(input int u, input logic [CW-1:0] want, input int unsigned lat);
        int unsigned nb;
        set_start(u, 1'b1);
        expect_job(u, want, cyc + 1 + lat);
        tick();
        set_start(u, 1'b0);
        wait_done(u, lat + 10, nb);
        check($sformatf("busy_cycles_u%0d", u), CW'(nb), CW'(lat));
        check($sformatf("busy_at_done_u%0d", u), CW'(busy_v[u]), '0);
    endtask

    localparam logic [CW-1:0] C_T1 = {65'd50, 65'd43, 65'd22, 65'd19};

    initial begin : stim
        int unsigned   c_start;
        int unsigned   nb;
        logic [161:0]  e_n3a, e_n3b;
        logic [71:0]   b_n3b;

        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        rst_n = 1'b0;
        tick();
        tick();
        check("reset_busy", CW'(bz0), '0);
        check("reset_done", CW'(dn0), '0);
        check("reset_c", c_v[0], '0);
        rst_n = 1'b1;
        tick();

        // Basic unsigned product, then a start pulse landing in DONE
        a0 = {32'd4, 32'd3, 32'd2, 32'd1};
        b0 = {32'd8, 32'd7, 32'd6, 32'd5};
        do_job(0, C_T1, 8);
        st0 = 1'b1;
        tick();
        st0 = 1'b0;
        check("start_in_done_ignored", CW'(bz0), '0);
        repeat (12) tick();

        // Full-scale unsigned operands: 65-bit result, no truncation
        a0 = {4{32'hFFFF_FFFF}};
        b0 = {4{32'hFFFF_FFFF}};
        do_job(0, {4{65'h1_FFFF_FFFC_0000_0002}}, 8);
        tick();

        // Signed operands
        a1 = {32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF};
        b1 = {32'd8, 32'd7, 32'hFFFF_FFFA, 32'd5};
        do_job(1, {65'h1_FFFF_FFFF_FFFF_FFF8, 65'h1_FFFF_FFFF_FFFF_FFF9,
                   65'd6, 65'h1_FFFF_FFFF_FFFF_FFFB}, 8);
        tick();
        a1 = {32'hFFFF_FFFB, 32'd4, 32'd2, 32'hFFFF_FFFD};
        b1 = {32'd6, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        do_job(1, {65'h1_FFFF_FFFF_FFFF_FFDE, 65'h1_FFFF_FFFF_FFFF_FFE9,
                   65'd15, 65'd12}, 8);
        tick();

        // Start and operand changes while busy must not disturb the job
        a0 = {32'd3, 32'd1, 32'd0, 32'd2};
        b0 = {32'd7, 32'd6, 32'd5, 32'd4};
        st0 = 1'b1;
        expect_job(0, {65'd26, 65'd22, 65'd10, 65'd8}, cyc + 9);
        tick();
        st0 = 1'b0;
        tick();
        tick();
        st0 = 1'b1;
        a0 = {4{32'd9}};
        b0 = {4{32'd11}};
        tick();
        st0 = 1'b0;
        wait_done(0, 20, nb);
        repeat (14) tick();

        // Reset in the middle of a job
        a0 = {32'd4, 32'd3, 32'd2, 32'd1};
        b0 = {32'd8, 32'd7, 32'd6, 32'd5};
        st0 = 1'b1;
        expect_job(0, C_T1, cyc + 9);
        tick();
        st0 = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        sb[0].delete();
        #1;
        check("midreset_busy", CW'(bz0), '0);
        check("midreset_done", CW'(dn0), '0);
        check("midreset_c", c_v[0], '0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_job(0, C_T1, 8);
        tick();

        // N=3: identity times B with start held high for two back-to-back jobs
        b_n3b = '0;
        e_n3a = '0;
        e_n3b = '0;
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < 3; s++) begin
                a2[(r*3+s)*8 +: 8]     = (r == s) ? 8'd1 : 8'd0;
                b2[(r*3+s)*8 +: 8]     = 8'(r*3 + s + 1);
                b_n3b[(r*3+s)*8 +: 8]  = 8'(9 - (r*3 + s));
                e_n3a[(r*3+s)*18 +: 18] = 18'(r*3 + s + 1);
                e_n3b[(r*3+s)*18 +: 18] = 18'(9 - (r*3 + s));
            end
        end
        c_start = cyc;
        st2 = 1'b1;
        expect_job(2, CW'(e_n3a), c_start + 1 + 27);
        expect_job(2, CW'(e_n3b), c_start + 1 + 29 + 27);
        tick();
        repeat (9) tick();
        b2 = b_n3b;
        repeat (30) tick();
        st2 = 1'b0;
        repeat (28) tick();

        for (int u = 0; u < 3; u++) begin
            check($sformatf("scoreboard_drained_u%0d", u), CW'(sb[u].size()), '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
